// File: rtl/cmp_pkg.sv
// Shared types and defaults for the comparator-result tally block.
package cmp_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    // Class of the most recent accepted sample; ClsNone after reset, clear or a malformed sample.
    typedef enum logic [1:0] {
        ClsNone,
        ClsGt,
        ClsLt,
        ClsEq
    } cls_e;

    // Snapshot handshake states.
    typedef enum logic {
        StIdle,
        StHold
    } state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_cnt
    import cmp_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] MaxVal = '1;

    logic [CNT_W-1:0] r_cnt;

    // Count register: reset/clear win, otherwise increment until saturated.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MaxVal)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cmp_tally.sv
// Tallies comparator results by class, tracks run lengths and offers a held snapshot.
module cmp_tally
    import cmp_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic             Gt,
    input  logic             Lt,
    input  logic             Eq,
    input  logic             clr,
    input  logic             rd_req,
    input  logic             snap_rdy,
    output logic             snap_vld,
    output logic [CNT_W-1:0] snap_gt,
    output logic [CNT_W-1:0] snap_lt,
    output logic [CNT_W-1:0] snap_eq,
    output logic [CNT_W-1:0] snap_err,
    output logic [CNT_W-1:0] snap_max_run,
    output logic [CNT_W-1:0] run_len
);

    localparam logic [CNT_W-1:0] MaxVal = '1;

    cls_e             w_cls;
    logic             w_accept;
    logic             w_valid;
    logic             w_err;
    logic [CNT_W-1:0] w_run_next;
    logic [CNT_W-1:0] w_gt_cnt;
    logic [CNT_W-1:0] w_lt_cnt;
    logic [CNT_W-1:0] w_eq_cnt;
    logic [CNT_W-1:0] w_err_cnt;
    logic             w_capture;
    state_e           w_state_next;

    cls_e             r_last_cls;
    logic [CNT_W-1:0] r_run_len;
    logic [CNT_W-1:0] r_max_run;
    state_e           r_state;
    logic [CNT_W-1:0] r_snap_gt;
    logic [CNT_W-1:0] r_snap_lt;
    logic [CNT_W-1:0] r_snap_eq;
    logic [CNT_W-1:0] r_snap_err;
    logic [CNT_W-1:0] r_snap_max;

    // Sample classification and the run length this sample would produce.
    always_comb begin
        w_accept = in_vld && !clr;
        unique case ({Gt, Lt, Eq})
            3'b100:  w_cls = ClsGt;
            3'b010:  w_cls = ClsLt;
            3'b001:  w_cls = ClsEq;
            default: w_cls = ClsNone;
        endcase
        w_valid = w_accept && (w_cls != ClsNone);
        w_err   = w_accept && (w_cls == ClsNone);
        if ((w_cls == r_last_cls) && (r_last_cls != ClsNone)) begin
            w_run_next = (r_run_len == MaxVal) ? r_run_len : r_run_len + CNT_W'(1);
        end else begin
            w_run_next = CNT_W'(1);
        end
    end

    sat_cnt #(.CNT_W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_valid && (w_cls == ClsGt)),
        .i_clr (clr),
        .o_cnt (w_gt_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_valid && (w_cls == ClsLt)),
        .i_clr (clr),
        .o_cnt (w_lt_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_valid && (w_cls == ClsEq)),
        .i_clr (clr),
        .o_cnt (w_eq_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_err),
        .i_clr (clr),
        .o_cnt (w_err_cnt)
    );

    // Run tracking: malformed samples break the run, max_run follows the new run on the same edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_last_cls <= ClsNone;
            r_run_len  <= '0;
            r_max_run  <= '0;
        end else if (w_err) begin
            r_last_cls <= ClsNone;
            r_run_len  <= '0;
        end else if (w_valid) begin
            r_last_cls <= w_cls;
            r_run_len  <= w_run_next;
            if (w_run_next > r_max_run) begin
                r_max_run <= w_run_next;
            end
        end
    end

    // Snapshot FSM next state; snap_vld is purely a function of the state register.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        snap_vld     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (rd_req) begin
                    w_capture    = 1'b1;
                    w_state_next = StHold;
                end
            end
            StHold: begin
                snap_vld = 1'b1;
                if (snap_rdy) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State and snapshot registers; capture takes pre-edge live values, clr never touches them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_snap_gt  <= '0;
            r_snap_lt  <= '0;
            r_snap_eq  <= '0;
            r_snap_err <= '0;
            r_snap_max <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_snap_gt  <= w_gt_cnt;
                r_snap_lt  <= w_lt_cnt;
                r_snap_eq  <= w_eq_cnt;
                r_snap_err <= w_err_cnt;
                r_snap_max <= r_max_run;
            end
        end
    end

    assign snap_gt      = r_snap_gt;
    assign snap_lt      = r_snap_lt;
    assign snap_eq      = r_snap_eq;
    assign snap_err     = r_snap_err;
    assign snap_max_run = r_snap_max;
    assign run_len      = r_run_len;

endmodule

// File: tb/tb_cmp_tally.sv
// Bench for cmp_tally: a 16-bit and a 4-bit instance share stimulus and are checked every cycle
// against a behavioural model, plus literal expectations for the directed scenarios.
module tb_cmp_tally;

    logic clk;
    logic rst, in_vld, gt, lt, eq, clr, rd_req, snap_rdy;

    logic        vld16;
    logic [15:0] sgt16, slt16, seq16, serr16, smax16, run16;
    logic        vld4;
    logic [3:0]  sgt4, slt4, seq4, serr4, smax4, run4;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    typedef struct {
        int gt, lt, eq, err, run, mx, last;
        bit hold;
        int sgt, slt, seq, serr, smx;
    } model_t;

    model_t m16 = '{default: 0};
    model_t m4  = '{default: 0};

    cmp_tally #(.CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .Gt(gt), .Lt(lt), .Eq(eq), .clr(clr),
        .rd_req(rd_req), .snap_rdy(snap_rdy), .snap_vld(vld16), .snap_gt(sgt16),
        .snap_lt(slt16), .snap_eq(seq16), .snap_err(serr16), .snap_max_run(smax16),
        .run_len(run16)
    );

    cmp_tally #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .Gt(gt), .Lt(lt), .Eq(eq), .clr(clr),
        .rd_req(rd_req), .snap_rdy(snap_rdy), .snap_vld(vld4), .snap_gt(sgt4),
        .snap_lt(slt4), .snap_eq(seq4), .snap_err(serr4), .snap_max_run(smax4),
        .run_len(run4)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int sat(int v, int lim);
        return (v > lim) ? lim : v;
    endfunction

    // One clock edge of the specified behaviour, computed from the pre-edge state m.
    function automatic model_t step(model_t m, int lim, bit r, bit v, bit g, bit l, bit e,
                                    bit c, bit rd, bit rdy);
        model_t n;
        int flags;
        int cls;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        n = m;
        if (!m.hold && rd) begin
            n.hold = 1;
            n.sgt  = m.gt;
            n.slt  = m.lt;
            n.seq  = m.eq;
            n.serr = m.err;
            n.smx  = m.mx;
        end else if (m.hold && rdy) begin
            n.hold = 0;
        end
        if (c) begin
            n.gt = 0; n.lt = 0; n.eq = 0; n.err = 0; n.run = 0; n.mx = 0; n.last = 0;
        end else if (v) begin
            flags = int'(g) + int'(l) + int'(e);
            if (flags != 1) begin
                n.err  = sat(m.err + 1, lim);
                n.run  = 0;
                n.last = 0;
            end else begin
                cls = g ? 1 : (l ? 2 : 3);
                if (cls == 1) n.gt = sat(m.gt + 1, lim);
                if (cls == 2) n.lt = sat(m.lt + 1, lim);
                if (cls == 3) n.eq = sat(m.eq + 1, lim);
                n.run  = (cls == m.last) ? sat(m.run + 1, lim) : 1;
                n.mx   = (n.run > m.mx) ? n.run : m.mx;
                n.last = cls;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m16 <= step(m16, 65535, rst, in_vld, gt, lt, eq, clr, rd_req, snap_rdy);
        m4  <= step(m4, 15, rst, in_vld, gt, lt, eq, clr, rd_req, snap_rdy);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("vld16", int'(vld16), int'(m16.hold));
            check("sgt16", int'(sgt16), m16.sgt);
            check("slt16", int'(slt16), m16.slt);
            check("seq16", int'(seq16), m16.seq);
            check("serr16", int'(serr16), m16.serr);
            check("smax16", int'(smax16), m16.smx);
            check("run16", int'(run16), m16.run);
            check("vld4", int'(vld4), int'(m4.hold));
            check("sgt4", int'(sgt4), m4.sgt);
            check("slt4", int'(slt4), m4.slt);
            check("seq4", int'(seq4), m4.seq);
            check("serr4", int'(serr4), m4.serr);
            check("smax4", int'(smax4), m4.smx);
            check("run4", int'(run4), m4.run);
        end
    end

    // Apply inputs just after a falling edge and return at the next falling edge.
    task automatic tick(input bit v, input bit g, input bit l, input bit e, input bit c,
                        input bit rd, input bit rdy, input bit r = 0);
        rst = r; in_vld = v; gt = g; lt = l; eq = e; clr = c; rd_req = rd; snap_rdy = rdy;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tick(0, 0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 0, 1);
        chk_en = 1;
        check("reset_vld", int'(vld16), 0);
        check("reset_run", int'(run16), 0);
        check("reset_sgt", int'(sgt16), 0);

        // Three Gt, snapshot, hold one cycle, then accept.
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1, 0);
        check("s1_vld", int'(vld16), 1);
        check("s1_sgt", int'(sgt16), 3);
        check("s1_smax", int'(smax16), 3);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("s1_vld_held", int'(vld16), 1);
        tick(0, 0, 0, 0, 0, 0, 1);
        check("s1_vld_drop", int'(vld16), 0);

        // Eq,Eq,Lt,Eq,Eq,Eq.
        tick(0, 0, 0, 0, 1, 0, 0);
        tick(1, 0, 0, 1, 0, 0, 0);
        tick(1, 0, 0, 1, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 1, 0, 0, 0);
        check("s2_run", int'(run16), 3);
        tick(0, 0, 0, 0, 0, 1, 0);
        check("s2_seq", int'(seq16), 5);
        check("s2_slt", int'(slt16), 1);
        check("s2_smax", int'(smax16), 3);
        tick(0, 0, 0, 0, 0, 0, 1);

        // Malformed samples, then a valid Gt.
        tick(0, 0, 0, 0, 1, 0, 0);
        tick(1, 1, 1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
        check("s3_run0", int'(run16), 0);
        tick(0, 0, 0, 0, 0, 1, 0);
        check("s3_serr", int'(serr16), 2);
        check("s3_sgt", int'(sgt16), 0);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 0, 0);
        check("s3_run1", int'(run16), 1);

        // Saturation on the 4-bit instance.
        tick(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) tick(1, 1, 0, 0, 0, 0, 0);
        check("s4_run4", int'(run4), 15);
        check("s4_run16", int'(run16), 17);
        tick(0, 0, 0, 0, 0, 1, 0);
        check("s4_sgt4", int'(sgt4), 15);
        check("s4_smax4", int'(smax4), 15);
        tick(0, 0, 0, 0, 0, 0, 1);

        // rd_req with same-cycle Lt; a second rd_req in HOLD is ignored.
        tick(0, 0, 0, 0, 1, 0, 0);
        tick(1, 0, 1, 0, 0, 1, 0);
        check("s5_slt_excl", int'(slt16), 0);
        tick(0, 0, 0, 0, 0, 1, 0);
        check("s5_slt_hold", int'(slt16), 0);
        check("s5_vld", int'(vld16), 1);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1, 0);
        check("s5_slt_live", int'(slt16), 1);
        tick(0, 0, 0, 0, 0, 0, 1);

        // clr with a sample in HOLD, then rst in HOLD.
        tick(0, 0, 0, 0, 1, 0, 0);
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1, 0);
        tick(1, 1, 0, 0, 1, 0, 0);
        check("s6_run", int'(run16), 0);
        check("s6_vld", int'(vld16), 1);
        check("s6_sgt", int'(sgt16), 2);
        check("s6_smax", int'(smax16), 2);
        tick(0, 0, 0, 0, 0, 0, 0, 1);
        check("s6_rst_vld", int'(vld16), 0);
        check("s6_rst_sgt", int'(sgt16), 0);
        idle_n(2);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 499) == 0);
        end
        idle_n(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_tally.md
CMP_TALLY -- requirements
Module: cmp_tally

Interface
REQ-001 Parameter: CNT_W, default 16, width of every counter and snapshot field.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_vld  input  1  Gt/Lt/Eq carry a comparator result this cycle.
REQ-005 Gt  input  1  upstream comparator greater-than flag.
REQ-006 Lt  input  1  upstream comparator less-than flag.
REQ-007 Eq  input  1  upstream comparator equal flag.
REQ-008 clr  input  1  synchronous clear of live counters.
REQ-009 rd_req  input  1  snapshot request.
REQ-010 snap_rdy  input  1  consumer accepts the snapshot.
REQ-011 snap_vld  output  1  snapshot fields are valid and held.
REQ-012 snap_gt, snap_lt, snap_eq  output  CNT_W each  snapshot of class counters.
REQ-013 snap_err  output  CNT_W  snapshot of the malformed-sample counter.
REQ-014 snap_max_run  output  CNT_W  snapshot of the longest run.
REQ-015 run_len  output  CNT_W  live length of the current run of identical results.

Function
REQ-016 A sample is accepted on an edge where in_vld=1, rst=0 and clr=0.
REQ-017 An accepted sample with exactly one of Gt/Lt/Eq high is valid; it increments the matching counter.
REQ-018 An accepted sample with zero or more than one flag high is malformed; it increments err_cnt, sets run_len to 0 and sets the last class to NONE.
REQ-019 Valid sample of the same class as the last class: run_len+1. Valid sample of a different class, or last class NONE: run_len=1.
REQ-020 On a valid sample, max_run is updated to max(max_run, new run_len) on the same edge.
REQ-021 All counters, run_len and max_run saturate at 2^CNT_W-1. They never wrap.
REQ-022 clr=1 zeroes all live counters, run_len and max_run, and sets the last class to NONE. clr has priority over a same-cycle sample, which is dropped.
REQ-023 The snapshot FSM has two states. IDLE: snap_vld=0. HOLD: snap_vld=1.
REQ-024 IDLE with rd_req=1: the snapshot registers capture the live counter values from before that edge's update, and the FSM enters HOLD at that edge. A same-cycle sample is counted live but is excluded from the snapshot.
REQ-025 HOLD: snapshot fields are stable. rd_req is ignored. An edge with snap_rdy=1 completes the transfer and the FSM returns to IDLE.
REQ-026 snap_rdy is a don't-care in IDLE. snap_vld never depends combinationally on snap_rdy.
REQ-027 Counting continues in both states. clr in HOLD clears the live state only; the held snapshot and snap_vld are unaffected.
REQ-028 A sample accepted at edge N is reflected in run_len after edge N (one-cycle latency).

Reset
REQ-029 rst=1 at an edge: all counters, run_len, max_run and snapshot fields become 0, the last class becomes NONE, the FSM enters IDLE (snap_vld=0). rst overrides clr, rd_req and samples.
REQ-030 rst asserted in HOLD abandons the pending snapshot; no transfer occurs.

Structure
REQ-031 Package cmp_pkg holds: the CNT_W default, the class enum {NONE, GT, LT, EQ}, and the FSM state typedef {IDLE, HOLD}.
REQ-032 Sub-module sat_cnt: CNT_W-bit saturating counter with inc and clr inputs. It is instantiated for the gt, lt, eq and err counters.
REQ-033 Run tracking, max_run and the snapshot FSM live in cmp_tally itself.

Verification
REQ-034 Reset, then 3 samples Gt=1, then rd_req, then snap_rdy=1 -> snap_gt=3, snap_max_run=3, snap_vld high exactly until the accepting edge.
REQ-035 Sequence Eq,Eq,Lt,Eq,Eq,Eq -> run_len=3, max_run=3, eq_cnt=5, lt_cnt=1.
REQ-036 Samples with flags {Gt,Lt}=1 and all-zero -> err_cnt=2, run_len=0, no class counter changes; the next valid Gt gives run_len=1.
REQ-037 CNT_W=4, 17 Gt samples -> gt_cnt, run_len and max_run all stay at 15.
REQ-038 rd_req with a same-cycle valid Lt sample -> snap_lt excludes it, live lt_cnt includes it. A further rd_req in HOLD changes nothing.
REQ-039 In HOLD, clr together with a sample -> the sample is dropped, live state is 0, and the snapshot is unchanged. rst in HOLD -> snap_vld=0 the next cycle.
